// File: rtl/regfile_mp.sv
// Multi-port register file: two combinational read ports, ALU and load write
// ports, a debug read port and a per-register load busy scoreboard.
module regfile_mp_cell #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wa,
  input  logic              wb,
  input  logic              mk,
  input  logic [DATA_W-1:0] wda,
  input  logic [DATA_W-1:0] wdb,
  output logic [DATA_W-1:0] q,
  output logic              busy
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q    <= '0;
      busy <= 1'b0;
    end else begin
      if (wb)      q <= wdb;
      else if (wa) q <= wda;
      // a new load issued in the same cycle outranks the completing one
      if (mk)      busy <= 1'b1;
      else if (wb) busy <= 1'b0;
    end
  end
endmodule

module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic              busy1,
  output logic              busy2,
  input  logic              wea,
  input  logic [ADDR_W-1:0] waa,
  input  logic [DATA_W-1:0] wda,
  input  logic              web,
  input  logic [ADDR_W-1:0] wab,
  input  logic [DATA_W-1:0] wdb,
  input  logic              mark,
  input  logic [ADDR_W-1:0] mark_addr,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic              busy_any
);
  logic [NUM_REGS-1:0][DATA_W-1:0] mem;
  logic [NUM_REGS-1:0]             busy;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    localparam bit WRITABLE = !(ZERO_REG != 0 && i == 0);
    logic hit_a, hit_b, hit_m;
    assign hit_a = WRITABLE && wea  && (waa       == ADDR_W'(i));
    assign hit_b = WRITABLE && web  && (wab       == ADDR_W'(i));
    assign hit_m = WRITABLE && mark && (mark_addr == ADDR_W'(i));
    regfile_mp_cell #(.DATA_W(DATA_W)) u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .wa    (hit_a),
      .wb    (hit_b),
      .mk    (hit_m),
      .wda   (wda),
      .wdb   (wdb),
      .q     (mem[i]),
      .busy  (busy[i])
    );
  end

  function automatic logic legal(input logic [ADDR_W-1:0] a);
    return (32'(a) < NUM_REGS) && !(ZERO_REG != 0 && a == '0);
  endfunction

  function automatic logic [DATA_W-1:0] stored(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (a == ADDR_W'(i)) v = mem[i];
    return v;
  endfunction

  function automatic logic busy_at(input logic [ADDR_W-1:0] a);
    logic v;
    v = 1'b0;
    for (int i = 0; i < NUM_REGS; i++)
      if (a == ADDR_W'(i)) v = busy[i];
    return v;
  endfunction

  // Forwarding is suppressed while in reset so outputs reflect the cleared state.
  logic byp;
  assign byp = (BYPASS != 0) && rst_n;

  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] a);
    if (!legal(a))                   return '0;
    else if (byp && web && wab == a) return wdb;
    else if (byp && wea && waa == a) return wda;
    else                             return stored(a);
  endfunction

  function automatic logic busy_port(input logic [ADDR_W-1:0] a);
    if (!legal(a)) return 1'b0;
    else if (byp && web && wab == a && !(mark && mark_addr == a)) return 1'b0;
    else return busy_at(a);
  endfunction

  always_comb begin
    rd1      = read_port(ra1);
    rd2      = read_port(ra2);
    busy1    = busy_port(ra1);
    busy2    = busy_port(ra2);
    dbg_data = legal(dbg_addr) ? stored(dbg_addr) : '0;
    busy_any = |busy;
  end
endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp; expectations queued as stimulus is applied.
module tb_regfile_mp;
  localparam int DW = 32, AW = 5, NR = 24;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] ra1, ra2, waa, wab, mark_addr, dbg_addr;
  logic [DW-1:0] rd1, rd2, wda, wdb, dbg_data;
  logic          busy1, busy2, wea, web, mark, busy_any;

  int vectors = 0, miscompares = 0;
  logic [DW-1:0] exp_q[$];
  string         tag_q[$];

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR), .ZERO_REG(1), .BYPASS(1)) dut (
    .clk(clk), .rst_n(rst_n), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .busy1(busy1), .busy2(busy2), .wea(wea), .waa(waa), .wda(wda),
    .web(web), .wab(wab), .wdb(wdb), .mark(mark), .mark_addr(mark_addr),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data), .busy_any(busy_any)
  );

  always #5 clk = ~clk;

  task automatic expect_val(input string tag, input logic [DW-1:0] v);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  task automatic chk(input logic [DW-1:0] obs);
    logic [DW-1:0] e;
    string t;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $error("FAIL scoreboard_empty: got %h want <none>", obs);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (obs === e) else begin
        miscompares++;
        $error("FAIL %s: got %h want %h", t, obs, e);
      end
    end
  endtask

  task automatic idle();
    wea = 0; waa = '0; wda = '0;
    web = 0; wab = '0; wdb = '0;
    mark = 0; mark_addr = '0;
  endtask

  // advance to just after the next rising edge, then let new inputs settle
  task automatic next();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n = 0; ra1 = '0; ra2 = '0; dbg_addr = '0;
    idle();
    // reset held with writes and marks active
    wea = 1; waa = 5'd3; wda = 32'h1234_5678;
    web = 1; wab = 5'd6; wdb = 32'h8765_4321;
    mark = 1; mark_addr = 5'd4;
    ra1 = 5'd3; ra2 = 5'd6; dbg_addr = 5'd3;
    @(posedge clk); @(posedge clk); #2;
    expect_val("rst_rd1", '0);     chk(rd1);
    expect_val("rst_rd2", '0);     chk(rd2);
    expect_val("rst_dbg", '0);     chk(dbg_data);
    expect_val("rst_busy_any", '0); chk(32'(busy_any));
    idle();
    #1 rst_n = 1;
    next();
    expect_val("post_rst_busy_any", '0); chk(32'(busy_any));
    expect_val("post_rst_dbg3", '0);     chk(dbg_data);

    // ALU write with same-cycle bypass; debug port is not bypassed
    wea = 1; waa = 5'd5; wda = 32'hDEAD_BEEF; ra1 = 5'd5; dbg_addr = 5'd5;
    #1;
    expect_val("byp_rd1", 32'hDEAD_BEEF); chk(rd1);
    expect_val("dbg_no_byp", '0);         chk(dbg_data);
    next(); idle(); #1;
    expect_val("dbg_reg5", 32'hDEAD_BEEF); chk(dbg_data);

    // write conflict: port B wins, both stored and bypassed
    wea = 1; waa = 5'd7; wda = 32'h1; web = 1; wab = 5'd7; wdb = 32'h2; ra2 = 5'd7;
    #1;
    expect_val("conflict_byp_rd2", 32'h2); chk(rd2);
    next(); idle(); dbg_addr = 5'd7; #1;
    expect_val("conflict_reg7", 32'h2); chk(dbg_data);

    // reg 0 is hardwired
    wea = 1; waa = '0; wda = 32'hFFFF_FFFF; mark = 1; mark_addr = '0; ra1 = '0;
    #1;
    expect_val("r0_byp_rd1", '0); chk(rd1);
    expect_val("r0_busy1", '0);   chk(32'(busy1));
    next(); idle(); dbg_addr = '0; #1;
    expect_val("r0_rd1", '0);       chk(rd1);
    expect_val("r0_dbg", '0);       chk(dbg_data);
    expect_val("r0_busy_any", '0);  chk(32'(busy_any));

    // illegal address (>= NUM_REGS): no bypass, no store, no mark
    web = 1; wab = 5'd25; wdb = 32'hCAFE_F00D; mark = 1; mark_addr = 5'd26; ra1 = 5'd25;
    #1;
    expect_val("ill_byp_rd1", '0); chk(rd1);
    next(); idle(); dbg_addr = 5'd25; #1;
    expect_val("ill_dbg", '0);      chk(dbg_data);
    expect_val("ill_busy_any", '0); chk(32'(busy_any));

    // scoreboard: mark, hold, clear with load writeback
    mark = 1; mark_addr = 5'd9; ra1 = 5'd9;
    next(); idle(); #1;
    expect_val("mark9_busy1", 1);    chk(32'(busy1));
    expect_val("mark9_busy_any", 1); chk(32'(busy_any));
    next();
    web = 1; wab = 5'd9; wdb = 32'h55; #1;
    expect_val("clr9_byp_busy1", 0); chk(32'(busy1));
    expect_val("clr9_byp_rd1", 32'h55); chk(rd1);
    next(); idle(); #1;
    expect_val("clr9_busy1", 0);    chk(32'(busy1));
    expect_val("clr9_busy_any", 0); chk(32'(busy_any));
    mark = 1; mark_addr = 5'd9; web = 1; wab = 5'd9; wdb = 32'h66;
    next(); idle(); #1;
    expect_val("markclr9_busy1", 1); chk(32'(busy1));
    expect_val("markclr9_rd1", 32'h66); chk(rd1);
    // an ALU write leaves the busy bit alone
    wea = 1; waa = 5'd9; wda = 32'h77;
    next(); idle(); #1;
    expect_val("alu9_busy1", 1);   chk(32'(busy1));
    expect_val("alu9_rd1", 32'h77); chk(rd1);

    // a few load writebacks, read back through the debug port
    for (int i = 10; i < 14; i++) begin
      web = 1; wab = AW'(i); wdb = 32'(i) * 32'h1111;
      next();
    end
    idle();
    for (int i = 10; i < 14; i++) begin
      dbg_addr = AW'(i); #1;
      expect_val("ldwb_dbg", 32'(i) * 32'h1111); chk(dbg_data);
    end

    // mid-cycle reset clears state immediately
    wea = 1; waa = 5'd3; wda = 32'hA5; mark = 1; mark_addr = 5'd4;
    next(); idle(); dbg_addr = 5'd3; ra2 = 5'd4; #1;
    expect_val("pre_rst_reg3", 32'hA5); chk(dbg_data);
    expect_val("pre_rst_busy4", 1);     chk(32'(busy2));
    rst_n = 0; #1;
    expect_val("midrst_reg3", '0);     chk(dbg_data);
    expect_val("midrst_busy4", 0);     chk(32'(busy2));
    expect_val("midrst_busy_any", 0);  chk(32'(busy_any));
    rst_n = 1;
    wea = 1; waa = 5'd3; wda = 32'h11; ra1 = 5'd3;
    next(); idle(); #1;
    expect_val("first_edge_write", 32'h11); chk(dbg_data);

    if (exp_q.size() != 0) begin
      miscompares++;
      $error("FAIL scoreboard_leftover: got %0d want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
